// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - state encodings and sizing constants for the stopwatch controller
package stopwatch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  localparam int DIG_W  = 4;
  localparam int NDIG   = 4;
  localparam int DISP_W = DIG_W * NDIG;

  // 50 MHz system clock down to the 100 Hz hundredths tick
  localparam int CLK_DIV_DEFAULT = 500000;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - button, counter-chain and display signals of stopwatch_ctrl
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;

  logic              btn_ss;
  logic              btn_clr;
  logic              btn_lap;
  logic              sat;
  logic [DISP_W-1:0] d_in;
  logic              tick;
  logic              run_en;
  logic              clr;
  logic [1:0]        state;
  logic [DISP_W-1:0] disp;
  logic              lap_hold;

  modport master (
    input  btn_ss, btn_clr, btn_lap, sat, d_in,
    output tick, run_en, clr, state, disp, lap_hold
  );

  modport slave (
    output btn_ss, btn_clr, btn_lap, sat, d_in,
    input  tick, run_en, clr, state, disp, lap_hold
  );

endinterface

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - 2-FF button synchronizer with registered one-cycle rising-edge pulse
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic       s1;
  logic       s2;
  logic       s3;
  logic [2:0] vld;

  // vld gates the detector until s3 holds a real sample, so a button held
  // through reset release never looks like a fresh press
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      vld   <= 3'b000;
      pulse <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      s3    <= s2;
      vld   <= {vld[1:0], 1'b1};
      pulse <= s2 & ~s3 & vld[2];
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch FSM, tick prescaler and display lap hold
// Optional lap-hold path enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  stopwatch_ctrl_if.master sw
);

  localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic          p_ss;
  logic          p_clr;
  logic [1:0]    state_q;
  logic [1:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic          run_q;
  logic          clr_q;

  btn_edge u_ss  (.clk(clk), .rst(rst), .btn(sw.btn_ss),  .pulse(p_ss));
  btn_edge u_clr (.clk(clk), .rst(rst), .btn(sw.btn_clr), .pulse(p_clr));

  // clear wins over start/stop and saturation in the same cycle
  always_comb begin
    state_nxt = state_q;
    if (p_clr) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (p_ss) state_nxt = ST_RUN;
        ST_RUN: begin
          if (sat_in()) state_nxt = ST_FULL;
          else if (p_ss) state_nxt = ST_PAUSE;
        end
        ST_PAUSE: if (p_ss) state_nxt = ST_RUN;
        default:  state_nxt = state_q;
      endcase
    end
  end

  function automatic logic sat_in();
    return sw.sat;
  endfunction

  // prescaler only moves in RUN so a resume finishes the interrupted period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      run_q   <= 1'b0;
      clr_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      state_q <= state_nxt;
      run_q   <= (state_nxt == ST_RUN);
      clr_q   <= p_clr;
      if (p_clr) begin
        cnt <= '0;
      end else if (state_q == ST_RUN) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      end
    end
  end

  assign sw.tick   = (state_q == ST_RUN) && (cnt == CNT_LAST);
  assign sw.run_en = run_q;
  assign sw.clr    = clr_q;
  assign sw.state  = state_q;

`ifdef STOPWATCH_LAP_EN
  logic              p_lap;
  logic [DISP_W-1:0] hold_q;
  logic              hold_on;

  btn_edge u_lap (.clk(clk), .rst(rst), .btn(sw.btn_lap), .pulse(p_lap));

  // a lap press only freezes while running, but always releases a frozen display
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q  <= '0;
      hold_on <= 1'b0;
    end else if (p_clr) begin
      hold_on <= 1'b0;
    end else if (p_lap) begin
      if (hold_on) begin
        hold_on <= 1'b0;
      end else if (state_q == ST_RUN) begin
        hold_q  <= sw.d_in;
        hold_on <= 1'b1;
      end
    end
  end

  assign sw.lap_hold = hold_on;
  assign sw.disp     = hold_on ? hold_q : sw.d_in;
`else
  logic unused_btn_lap;
  assign unused_btn_lap = sw.btn_lap;
  assign sw.lap_hold    = 1'b0;
  assign sw.disp        = sw.d_in;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed self-checking bench for stopwatch_ctrl with CLK_DIV=4
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  logic clk = 1'b0;
  logic rst;

  stopwatch_ctrl_if sw ();

  stopwatch_ctrl #(.CLK_DIV(4)) dut (
    .clk(clk),
    .rst(rst),
    .sw (sw)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;
  int pss_n = 0;
  int clr_n = 0;
  int tick_n = 0;
  int last_tick = -1;
  int first_pss = -1;
  int first_run = -1;
  int first_runen = -1;
  int tick_q[$];
  int n0;
  int c0;
  int p0;
  logic        exp_h;
  logic [15:0] exp_d;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
    if (dut.p_ss) begin
      pss_n++;
      if (first_pss < 0) first_pss = k;
    end
    if (sw.clr) clr_n++;
    if (sw.tick) begin
      tick_n++;
      last_tick = k;
      tick_q.push_back(k);
    end
    if (sw.state == ST_RUN && first_run < 0) first_run = k;
    if (sw.run_en && first_runen < 0) first_runen = k;
  endtask

  task automatic run_to(input int t);
    while (k < t) step();
  endtask

  initial begin
`ifdef STOPWATCH_LAP_EN
    exp_h = 1'b1;
    exp_d = 16'h0123;
`else
    exp_h = 1'b0;
    exp_d = 16'h0150;
`endif
    rst        = 1'b0;
    sw.btn_ss  = 1'b0;
    sw.btn_clr = 1'b0;
    sw.btn_lap = 1'b0;
    sw.sat     = 1'b0;
    sw.d_in    = 16'h1234;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_state",  sw.state,    ST_IDLE);
    check_eq("rst_run_en", sw.run_en,   1'b0);
    check_eq("rst_tick",   sw.tick,     1'b0);
    check_eq("rst_clr",    sw.clr,      1'b0);
    check_eq("rst_lap",    sw.lap_hold, 1'b0);
    check_eq("rst_disp",   sw.disp,     16'h1234);
    check_eq("rst_cnt",    dut.cnt,     0);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // start, button held 10 cycles
    k = 0;
    sw.btn_ss = 1'b1;
    run_to(10);
    sw.btn_ss = 1'b0;
    run_to(20);
    check_eq("pss_count",   pss_n,       1);
    check_eq("pss_at",      first_pss,   3);
    check_eq("run_state_at", first_run,  4);
    check_eq("run_en_at",   first_runen, 4);
    check_eq("tick_count",  tick_q.size(), 4);
    check_eq("tick_first",  tick_q[0],   7);
    check_eq("tick_period", tick_q[1] - tick_q[0], 4);

    // pause with prescaler at 2, then resume
    run_to(22);
    sw.btn_ss = 1'b1;
    run_to(26);
    check_eq("pause_state",  sw.state,  ST_PAUSE);
    check_eq("pause_run_en", sw.run_en, 1'b0);
    check_eq("pause_cnt",    dut.cnt,   2);
    n0 = tick_n;
    run_to(28);
    sw.btn_ss = 1'b0;
    run_to(40);
    check_eq("pause_no_tick", tick_n, n0);
    sw.btn_ss = 1'b1;
    run_to(44);
    check_eq("resume_state",  sw.state,  ST_RUN);
    check_eq("resume_run_en", sw.run_en, 1'b1);
    run_to(45);
    check_eq("resume_tick_at", last_tick, 45);
    run_to(46);
    sw.btn_ss = 1'b0;

    // saturation in RUN
    run_to(48);
    sw.sat = 1'b1;
    run_to(49);
    check_eq("full_state",  sw.state,  ST_FULL);
    check_eq("full_run_en", sw.run_en, 1'b0);
    check_eq("full_tick",   sw.tick,   1'b0);
    n0 = tick_n;
    run_to(53);
    check_eq("full_no_tick", tick_n, n0);
    sw.btn_ss = 1'b1;
    run_to(55);
    sw.btn_ss = 1'b0;
    run_to(58);
    check_eq("full_ss_ignored", sw.state, ST_FULL);
    run_to(60);
    sw.btn_clr = 1'b1;
    c0 = clr_n;
    run_to(62);
    sw.btn_clr = 1'b0;
    run_to(64);
    check_eq("full_clr_state", sw.state, ST_IDLE);
    check_eq("full_clr_pulse", sw.clr,   1'b1);
    check_eq("full_clr_cnt",   dut.cnt,  0);
    sw.sat = 1'b0;
    run_to(66);
    check_eq("clr_one_cycle", sw.clr, 1'b0);
    check_eq("clr_count",     clr_n - c0, 1);

    // start/stop and clear rising together in RUN
    run_to(70);
    sw.btn_ss = 1'b1;
    run_to(72);
    sw.btn_ss = 1'b0;
    run_to(74);
    check_eq("run2_state", sw.state, ST_RUN);
    run_to(78);
    sw.btn_ss  = 1'b1;
    sw.btn_clr = 1'b1;
    c0 = clr_n;
    run_to(80);
    sw.btn_ss  = 1'b0;
    sw.btn_clr = 1'b0;
    run_to(82);
    check_eq("both_state", sw.state, ST_IDLE);
    check_eq("both_clr",   sw.clr,   1'b1);
    check_eq("both_cnt",   dut.cnt,  0);
    run_to(86);
    check_eq("both_state_hold", sw.state,   ST_IDLE);
    check_eq("both_clr_count",  clr_n - c0, 1);

    // saturation while paused
    run_to(90);
    sw.btn_ss = 1'b1;
    run_to(92);
    sw.btn_ss = 1'b0;
    run_to(96);
    sw.btn_ss = 1'b1;
    run_to(98);
    sw.btn_ss = 1'b0;
    run_to(100);
    check_eq("pause2_state", sw.state, ST_PAUSE);
    sw.sat = 1'b1;
    run_to(103);
    check_eq("pause_sat_state",  sw.state,  ST_PAUSE);
    check_eq("pause_sat_run_en", sw.run_en, 1'b0);
    sw.sat = 1'b0;
    run_to(104);
    sw.btn_clr = 1'b1;
    run_to(106);
    sw.btn_clr = 1'b0;
    run_to(108);
    check_eq("pause_clr_state", sw.state, ST_IDLE);

    // lap hold while running
    run_to(110);
    sw.btn_ss = 1'b1;
    run_to(112);
    sw.btn_ss = 1'b0;
    run_to(114);
    check_eq("run3_state", sw.state, ST_RUN);
    sw.d_in = 16'h0123;
    run_to(115);
    sw.btn_lap = 1'b1;
    run_to(117);
    sw.btn_lap = 1'b0;
    run_to(120);
    sw.d_in = 16'h0150;
    #1;
    check_eq("lap_hold_on", sw.lap_hold, exp_h);
    check_eq("lap_disp",    sw.disp,     exp_d);
    run_to(122);
    sw.btn_lap = 1'b1;
    run_to(124);
    sw.btn_lap = 1'b0;
    run_to(126);
    check_eq("lap_release",      sw.lap_hold, 1'b0);
    check_eq("lap_release_disp", sw.disp,     16'h0150);
    run_to(127);
    sw.btn_lap = 1'b1;
    run_to(129);
    sw.btn_lap = 1'b0;
    run_to(133);
    check_eq("pre_rst_state", sw.state,    ST_RUN);
    check_eq("pre_rst_lap",   sw.lap_hold, exp_h);

    // asynchronous reset mid-RUN, released with start/stop held
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_state",  sw.state,    ST_IDLE);
    check_eq("arst_run_en", sw.run_en,   1'b0);
    check_eq("arst_tick",   sw.tick,     1'b0);
    check_eq("arst_clr",    sw.clr,      1'b0);
    check_eq("arst_lap",    sw.lap_hold, 1'b0);
    check_eq("arst_disp",   sw.disp,     16'h0150);
    check_eq("arst_cnt",    dut.cnt,     0);
    sw.btn_ss = 1'b1;
    p0 = pss_n;
    repeat (3) step();
    rst = 1'b1;
    repeat (8) step();
    check_eq("held_rel_state",  sw.state,  ST_IDLE);
    check_eq("held_rel_run_en", sw.run_en, 1'b0);
    check_eq("held_rel_pss",    pss_n,     p0);
    sw.btn_ss = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for the 4-digit BCD stopwatch counter chain. Conditions raw Start/Stop, Clear and Lap buttons, runs the stopwatch state machine, and generates the 0.01 s `tick` from the system clock. Drives the chain's `tick`, `en` and `rst` inputs. Owns the display hold (lap) path between the chain digits and the 7-segment driver.

## Interface
- `CLK_DIV`, 500000, system clocks per tick (50 MHz → 100 Hz); legal range ≥ 2
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset (0 = reset)
- `btn_ss`  in  1  raw Start/Stop button, active-high, asynchronous to `clk`
- `btn_clr`  in  1  raw Clear button, active-high, asynchronous
- `btn_lap`  in  1  raw Lap button, active-high, asynchronous
- `sat`  in  1  chain saturated (all digits 9)
- `d_in`  in  16  chain digits {d3,d2,d1,d0}
- `tick`  out  1  one-cycle 0.01 s pulse to chain
- `run_en`  out  1  chain count enable
- `clr`  out  1  one-cycle clear pulse to chain
- `state`  out  2  current FSM state, for LEDs and debug
- `disp`  out  16  digits for display
- `lap_hold`  out  1  display is frozen

## Operation
- **Button conditioning.** Each button passes through a 2-FF synchronizer and a registered rising-edge detector. The result is a one-cycle press pulse (`p_ss`, `p_clr`, `p_lap`). A held button produces exactly one pulse.
- **FSM states.** IDLE=00, RUN=01, PAUSE=10, FULL=11.
  - IDLE: `p_ss` → RUN.
  - RUN: `sat` → FULL; else `p_ss` → PAUSE.
  - PAUSE: `p_ss` → RUN.
  - FULL: `p_ss` ignored.
  - Any state: `p_clr` → IDLE. This has priority over `p_ss` and `sat` in the same cycle.
- **Clear.** `clr` = registered `p_clr`, asserted for exactly one cycle. On `p_clr` the prescaler is also zeroed.
- **Prescaler.** Counter over 0..`CLK_DIV`-1, width $clog2(`CLK_DIV`).
  - Advances only in RUN.
  - Holds its value in PAUSE and FULL, so resume continues the partial period.
  - `tick` = 1 for the cycle in which the counter equals `CLK_DIV`-1 and state is RUN. The counter wraps to 0 on the next edge.
- **Run enable.** `run_en` = registered (next state == RUN), so it is aligned with `state`.
- **Saturation.** `sat` asserting while in PAUSE does not change state.
- **Display.** `disp` = `d_in` whenever `lap_hold` = 0.

## Timing
- **Reset values:**
  - state IDLE
  - prescaler 0
  - `tick`, `run_en`, `clr` = 0
  - `lap_hold` = 0
  - `disp` follows `d_in`
  - all synchronizer and edge registers 0
- **Latency, button pin to press pulse:** 3 cycles (2 sync + 1 edge).
- **Latency, press pulse to `state`/`run_en`:** 1 cycle.
- **Latency, press pulse to `clr`:** 1 cycle.
- **Press pulse in RUN:** `tick` may still fire in the same cycle as the press pulse. It never fires in the cycle after the state has left RUN.
- **Period:** the first `tick` after IDLE→RUN arrives `CLK_DIV` cycles after `run_en` rises. Steady-state period is exactly `CLK_DIV`.
- **Reset mid-operation:** all outputs return to reset values asynchronously. Reset release is synchronous to `clk`; no press pulse is generated from a button already held at release.

## Configuration
- **`STOPWATCH_LAP_EN` defined:**
  - `p_lap` in RUN with `lap_hold`=0: latch `d_in` into the hold register and set `lap_hold`.
  - `p_lap` with `lap_hold`=1, in any state: clear `lap_hold`.
  - `p_lap` in IDLE, PAUSE or FULL with `lap_hold`=0: ignored.
  - `p_clr` clears `lap_hold`.
  - While `lap_hold`=1, `disp` = hold register. The chain keeps counting.
- **Not defined:**
  - lap logic is absent and `btn_lap` is unused
  - `lap_hold` is tied 0
  - `disp` = `d_in`
  - the port list is identical in both builds

## Structure
- **Package `stopwatch_pkg`:**
  - state localparams `ST_IDLE`, `ST_RUN`, `ST_PAUSE`, `ST_FULL` (2-bit)
  - `DIG_W`=4, `NDIG`=4
  - default `CLK_DIV`
- **Sub-module `btn_edge`:** synchronizer plus rising-edge pulse, with the same `clk`/`rst` convention. Instantiated once per button.
- **In the top:** FSM, prescaler and lap register.

## Test plan
(All scenarios use `CLK_DIV`=4.)
- Reset, then press `btn_ss` for 10 cycles:
  - exactly one `p_ss`
  - `state` 00→01 four cycles after the press edge
  - `tick` every 4 cycles, first one 4 cycles after `run_en` rises
- RUN, pause after 2 prescaler counts, resume:
  - no `tick` during PAUSE
  - first `tick` after resume arrives after 2 cycles (partial period preserved)
- RUN, drive `sat`=1: `state`=11 next cycle, `run_en`=0, `tick` stays 0. `btn_ss` press: no change. `btn_clr` press: `state`=00 and one-cycle `clr`.
- `btn_ss` and `btn_clr` rising in the same cycle from RUN: `state`=00, `clr` pulses once, prescaler reads 0.
- `STOPWATCH_LAP_EN`, RUN with `d_in`=16'h0123, press lap:
  - `lap_hold`=1 and `disp`=16'h0123 while `d_in` changes to 16'h0150
  - second lap press: `disp`=16'h0150 the next cycle
- Assert `rst`=0 mid-RUN with `lap_hold`=1: all outputs reach reset values without a clock edge. Release with `btn_ss` held high: no state change.
